// File: rtl/pc_gen_param_pkg.sv
// Shared definitions for the parametrised PC generator: FSM encoding,
// default start address, reset/stall polarity constants and alignment helper.
package pc_gen_param_pkg;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [63:0] DEF_START_ADDR = 64'h0000_0000_8000_0000;

  localparam logic STOP   = 1'b1;
  localparam logic RSTENA = 1'b0;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return (lo_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_param_if.sv
// Redirect/handshake bundle between ctrl/ID/EX, the PC generator and IF.
// Carries misalign_o only when PC_GEN_MISALIGN_CHK_EN is defined.
interface pc_gen_param_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 2
);
  logic [ADDR_W-1:0] static_pc_i;
  logic [ADDR_W-1:0] id_pc_i;
  logic              id_pc_ena;
  logic [ADDR_W-1:0] ex_pc_i;
  logic              ex_pc_ena;
  logic              pip_btype;
  logic              pc_stall;
  logic              if_ready;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [CNT_W-1:0]  pip_b_cont;
  logic              ce;
`ifdef PC_GEN_MISALIGN_CHK_EN
  logic              misalign_o;

  modport master (
    output static_pc_i, id_pc_i, id_pc_ena, ex_pc_i, ex_pc_ena,
    output pip_btype, pc_stall, if_ready,
    input  pc, pc_valid, pip_b_cont, ce, misalign_o
  );
  modport slave (
    input  static_pc_i, id_pc_i, id_pc_ena, ex_pc_i, ex_pc_ena,
    input  pip_btype, pc_stall, if_ready,
    output pc, pc_valid, pip_b_cont, ce, misalign_o
  );
`else
  modport master (
    output static_pc_i, id_pc_i, id_pc_ena, ex_pc_i, ex_pc_ena,
    output pip_btype, pc_stall, if_ready,
    input  pc, pc_valid, pip_b_cont, ce
  );
  modport slave (
    input  static_pc_i, id_pc_i, id_pc_ena, ex_pc_i, ex_pc_ena,
    input  pip_btype, pc_stall, if_ready,
    output pc, pc_valid, pip_b_cont, ce
  );
`endif
endinterface

// File: rtl/pc_gen_param_sat_counter.sv
// Saturating up/down counter; decrement wins when both requests are high.
// Shared with the branch history table.
module sat_counter #(
  parameter int           W    = 2,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] L_MAX  = '1;
  localparam logic [W-1:0] L_ZERO = '0;
  localparam logic [W-1:0] L_ONE  = W'(1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  // Next count with saturation at both ends.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (dec) begin
      if (r_cnt != L_ZERO) begin
        w_cnt_nxt = r_cnt - L_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (inc) begin
      if (r_cnt != L_MAX) begin
        w_cnt_nxt = r_cnt + L_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= INIT;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/pc_gen_param.sv
// Fetch-address generator with EX > ID > stall > sequential priority,
// valid/ready toward IF and post-EX flush bubbles. Option: PC_GEN_MISALIGN_CHK_EN.
module pc_gen_param
  import pc_gen_param_pkg::*;
#(
  parameter int                ADDR_W        = 64,
  parameter logic [63:0]       START_ADDR    = DEF_START_ADDR,
  parameter int                CNT_W         = 2,
  parameter logic [CNT_W-1:0]  CNT_INIT      = '1,
  parameter int                FLUSH_BUBBLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  pc_gen_param_if.slave        bus
);
  localparam logic [ADDR_W-1:0] L_START = START_ADDR[ADDR_W-1:0];
  localparam logic [1:0]        L_BUB   = 2'(FLUSH_BUBBLES);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_bub;
  logic [1:0]        w_bub_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_pc_load;
  logic              r_pc_valid;
  logic              r_ce;
  logic [CNT_W-1:0]  w_cnt;

  // State/bubble progression, then pc selection; redirects override the state.
  always_comb begin
    w_state_nxt = r_state;
    w_bub_nxt   = r_bub;
    w_pc_nxt    = r_pc;
    w_pc_load   = 1'b0;
    case (r_state)
      S_INIT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      S_FLUSH: begin
        if (r_bub <= 2'd1) begin
          w_state_nxt = S_RUN;
          w_bub_nxt   = 2'd0;
        end else begin
          w_state_nxt = S_FLUSH;
          w_bub_nxt   = r_bub - 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_bub_nxt   = 2'd0;
      end
    endcase

    // A held request (valid without ready) must stay put unless redirected.
    if (bus.ex_pc_ena) begin
      w_pc_nxt    = bus.ex_pc_i;
      w_pc_load   = 1'b1;
      w_state_nxt = S_FLUSH;
      w_bub_nxt   = L_BUB;
    end else if (bus.id_pc_ena) begin
      w_pc_nxt  = bus.id_pc_i;
      w_pc_load = 1'b1;
    end else if ((r_state == S_RUN) && !bus.pc_stall && !(r_pc_valid && !bus.if_ready)) begin
      w_pc_nxt  = bus.static_pc_i;
      w_pc_load = 1'b1;
    end else begin
      w_pc_nxt  = r_pc;
      w_pc_load = 1'b0;
    end
  end

  // FSM, pc and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_INIT;
      r_bub      <= 2'd0;
      r_pc       <= L_START;
      r_pc_valid <= 1'b0;
      r_ce       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bub      <= w_bub_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= (w_state_nxt == S_RUN);
      r_ce       <= (w_state_nxt != S_INIT);
    end
  end

  sat_counter #(
    .W    (CNT_W),
    .INIT (CNT_INIT)
  ) u_conf_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (bus.pip_btype),
    .dec   (bus.ex_pc_ena),
    .cnt   (w_cnt)
  );

`ifdef PC_GEN_MISALIGN_CHK_EN
  logic r_misalign;

  // Flag each load of a misaligned address for a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_pc_load && is_misaligned(w_pc_nxt[1:0]);
    end
  end

  assign bus.misalign_o = r_misalign;
`endif

  assign bus.pc         = r_pc;
  assign bus.pc_valid   = r_pc_valid;
  assign bus.ce         = r_ce;
  assign bus.pip_b_cont = w_cnt;
endmodule

// File: tb/tb_pc_gen_param.sv
// Directed self-checking bench for pc_gen_param (default parameters).
module tb_pc_gen_param;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_gen_param_if #(.ADDR_W(64), .CNT_W(2)) bus ();

  pc_gen_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.static_pc_i = 64'h0000_0000_8000_0000;
    bus.id_pc_i     = 64'h0;
    bus.id_pc_ena   = 1'b0;
    bus.ex_pc_i     = 64'h0;
    bus.ex_pc_ena   = 1'b0;
    bus.pip_btype   = 1'b0;
    bus.pc_stall    = 1'b0;
    bus.if_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.static_pc_i = 64'h0000_0000_8000_0004;
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL rst_pc actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0000); end
    checks++; if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b expected=0", bus.pc_valid); end
    checks++; if (bus.ce !== 1'b0) begin failures++; $display("FAIL rst_ce actual=%b expected=0", bus.ce); end
    checks++; if (bus.pip_b_cont !== 2'b11) begin failures++; $display("FAIL rst_cnt actual=%0d expected=3", bus.pip_b_cont); end
    rst = 1'b1;
    #1;
    checks++; if (bus.pc_valid !== 1'b0 || bus.ce !== 1'b0) begin failures++; $display("FAIL init_outputs actual=%b%b expected=00", bus.pc_valid, bus.ce); end
    @(negedge clk);
    step();
    checks++; if (bus.pc_valid !== 1'b1 || bus.ce !== 1'b1) begin failures++; $display("FAIL run_outputs actual=%b%b expected=11", bus.pc_valid, bus.ce); end
    checks++; if (bus.pc !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL init_pc_hold actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0000); end
  endtask

  task automatic test_handshake();
    bus.if_ready    = 1'b1;
    bus.static_pc_i = 64'h0000_0000_8000_0004;
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0004) begin failures++; $display("FAIL seq_pc actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0004); end
    bus.if_ready    = 1'b0;
    bus.static_pc_i = 64'h0000_0000_8000_0008;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 64'h0000_0000_8000_0004 || bus.pc_valid !== 1'b1) begin failures++; $display("FAIL hold_not_ready[%0d] actual=%h/%b expected=%h/1", i, bus.pc, bus.pc_valid, 64'h0000_0000_8000_0004); end
    end
    bus.if_ready = 1'b1;
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0008) begin failures++; $display("FAIL accept_resume actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0008); end
  endtask

  task automatic test_counter();
    logic [1:0] exp_dec [4];
    logic [1:0] exp_inc [4];
    exp_dec = '{2'd2, 2'd1, 2'd0, 2'd0};
    exp_inc = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    bus.if_ready = 1'b1;
    checks++; if (bus.pip_b_cont !== 2'd3) begin failures++; $display("FAIL cnt_start actual=%0d expected=3", bus.pip_b_cont); end
    bus.ex_pc_i = 64'h0000_0000_8000_0010;
    for (int i = 0; i < 4; i++) begin
      bus.ex_pc_ena = 1'b1;
      step();
      checks++; if (bus.pip_b_cont !== exp_dec[i]) begin failures++; $display("FAIL cnt_dec[%0d] actual=%0d expected=%0d", i, bus.pip_b_cont, exp_dec[i]); end
    end
    bus.ex_pc_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pip_btype = 1'b1;
      step();
      checks++; if (bus.pip_b_cont !== exp_inc[i]) begin failures++; $display("FAIL cnt_inc[%0d] actual=%0d expected=%0d", i, bus.pip_b_cont, exp_inc[i]); end
    end
    bus.pip_btype = 1'b0;
    bus.ex_pc_ena = 1'b1;
    step();
    checks++; if (bus.pip_b_cont !== 2'd2) begin failures++; $display("FAIL cnt_to_two actual=%0d expected=2", bus.pip_b_cont); end
    bus.pip_btype = 1'b1;
    step();
    checks++; if (bus.pip_b_cont !== 2'd1) begin failures++; $display("FAIL cnt_both actual=%0d expected=1", bus.pip_b_cont); end
    bus.pip_btype = 1'b0;
    bus.ex_pc_ena = 1'b0;
    step();
  endtask

  task automatic test_priority();
    bus.if_ready    = 1'b1;
    bus.static_pc_i = 64'h0000_0000_8000_0300;
    bus.ex_pc_ena   = 1'b1;
    bus.ex_pc_i     = 64'h0000_0000_8000_0100;
    bus.id_pc_ena   = 1'b1;
    bus.id_pc_i     = 64'h0000_0000_8000_0200;
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0100) begin failures++; $display("FAIL ex_over_id actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0100); end
    checks++; if (bus.pc_valid !== 1'b0 || bus.ce !== 1'b1) begin failures++; $display("FAIL flush_outputs actual=%b%b expected=01", bus.pc_valid, bus.ce); end
    bus.ex_pc_ena = 1'b0;
    bus.id_pc_ena = 1'b0;
    step();
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'h0000_0000_8000_0100) begin failures++; $display("FAIL flush_exit actual=%b/%h expected=1/%h", bus.pc_valid, bus.pc, 64'h0000_0000_8000_0100); end
    bus.ex_pc_ena = 1'b1;
    bus.ex_pc_i   = 64'h0000_0000_8000_0180;
    step();
    bus.ex_pc_i   = 64'h0000_0000_8000_01C0;
    step();
    checks++; if (bus.pc_valid !== 1'b0 || bus.pc !== 64'h0000_0000_8000_01C0) begin failures++; $display("FAIL flush_reload actual=%b/%h expected=0/%h", bus.pc_valid, bus.pc, 64'h0000_0000_8000_01C0); end
    bus.ex_pc_ena = 1'b0;
    step();
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'h0000_0000_8000_01C0) begin failures++; $display("FAIL reload_exit actual=%b/%h expected=1/%h", bus.pc_valid, bus.pc, 64'h0000_0000_8000_01C0); end
  endtask

  task automatic test_stall();
    bus.if_ready    = 1'b1;
    bus.pc_stall    = 1'b1;
    bus.id_pc_ena   = 1'b1;
    bus.id_pc_i     = 64'h0000_0000_8000_0040;
    bus.static_pc_i = 64'h0000_0000_8000_0044;
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0040) begin failures++; $display("FAIL id_over_stall actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0040); end
    bus.id_pc_ena = 1'b0;
    step();
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0040) begin failures++; $display("FAIL stall_hold actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0040); end
    bus.pc_stall = 1'b0;
    step();
    checks++; if (bus.pc !== 64'h0000_0000_8000_0044) begin failures++; $display("FAIL stall_release actual=%h expected=%h", bus.pc, 64'h0000_0000_8000_0044); end
  endtask

  task automatic test_reset_mid_flush();
    bus.ex_pc_ena = 1'b1;
    bus.ex_pc_i   = 64'h0000_0000_8000_0500;
    step();
    bus.ex_pc_ena = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.pc !== 64'h0000_0000_8000_0000 || bus.pc_valid !== 1'b0 || bus.ce !== 1'b0) begin failures++; $display("FAIL async_rst actual=%h/%b/%b expected=%h/0/0", bus.pc, bus.pc_valid, bus.ce, 64'h0000_0000_8000_0000); end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL post_rst_run actual=%b/%h expected=1/%h", bus.pc_valid, bus.pc, 64'h0000_0000_8000_0000); end
  endtask

`ifdef PC_GEN_MISALIGN_CHK_EN
  task automatic test_misalign();
    checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("FAIL misalign_idle actual=%b expected=0", bus.misalign_o); end
    bus.ex_pc_ena = 1'b1;
    bus.ex_pc_i   = 64'h0000_0000_8000_0102;
    step();
    checks++; if (bus.misalign_o !== 1'b1 || bus.pc !== 64'h0000_0000_8000_0102) begin failures++; $display("FAIL misalign_set actual=%b/%h expected=1/%h", bus.misalign_o, bus.pc, 64'h0000_0000_8000_0102); end
    bus.ex_pc_ena = 1'b0;
    step();
    checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("FAIL misalign_pulse actual=%b expected=0", bus.misalign_o); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_handshake();
    test_counter();
    test_priority();
    test_stall();
    test_reset_mid_flush();
`ifdef PC_GEN_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
